// File: rtl/imem_loader_if.sv
// ============================================================================
// Module  : imem_loader_if
// Brief   : Control, byte-stream and instruction-memory write bus of imem_loader
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              start;
    logic [ADDR_W-1:0] word_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Assembles a little-endian byte stream into 32-bit words and writes
//           them to instruction memory while holding the CPU.
//           Optional checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    imem_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_CHK   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [31:0]       buf_q, buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            buf_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            buf_q      <= buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        buf_d      = buf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    count_d    = bus.word_count;
                    byte_idx_d = '0;
                    word_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    err_d      = 1'b0;
`endif
                    state_d    = (bus.word_count == '0) ? S_DONE : S_RECV;
                end
            end
            // in_ready is high throughout RECV, so in_valid alone qualifies a transfer
            S_RECV: begin
                if (bus.in_valid) begin
                    buf_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ bus.in_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + ADDR_W'(1);
                if (word_idx_d == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (bus.in_valid) begin
                    err_d   = (bus.in_data != csum_q);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Address and data are forced to zero outside WRITE so reset/idle show all-zero outputs
    assign bus.imem_we    = (state_q == S_WRITE);
    assign bus.imem_addr  = (state_q == S_WRITE) ? (c_base_addr + word_idx_q) : '0;
    assign bus.imem_wdata = (state_q == S_WRITE) ? buf_q : '0;
    assign bus.done       = (state_q == S_DONE);
    assign bus.cpu_hold   = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.in_ready   = (state_q == S_RECV) || (state_q == S_CHK);
    assign bus.err        = err_q;
`else
    assign bus.in_ready   = (state_q == S_RECV);
    assign bus.err        = 1'b0;
`endif

endmodule

`default_nettype wire
